// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, FSM encoding and width defaults
package axil_pkg;

    localparam int AXIL_ADDR_WIDTH = 7;
    localparam int AXIL_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// rtl/axil_master_bridge.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp interface
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int         C_M_AXI_DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter logic [2:0] C_M_AXI_PROT       = 3'b000
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [7:0]                      err_count,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    state_t                          r_state;
    state_t                          w_next;

    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_arvalid;
    logic                            r_rready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]               r_wstrb;

    logic                            r_rsp_write;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                      r_rsp_resp;
    logic [7:0]                      r_err_count;

    logic                            w_cmd_ready;
    logic                            w_rsp_valid;
    logic                            w_accept;
    logic                            w_aw_ok;
    logic                            w_w_ok;
    logic                            w_b_cap;
    logic                            w_r_cap;
    logic                            w_cap_err;

    assign w_accept  = cmd_valid && w_cmd_ready;
    // A channel counts as done once its VALID has dropped or is handshaking now.
    assign w_aw_ok   = !r_awvalid || M_AXI_AWREADY;
    assign w_w_ok    = !r_wvalid  || M_AXI_WREADY;
    assign w_b_cap   = (r_state == ST_WR_RESP) && M_AXI_BVALID;
    assign w_r_cap   = (r_state == ST_RD_RESP) && M_AXI_RVALID;
    assign w_cap_err = resp_is_err(w_b_cap ? M_AXI_BRESP : M_AXI_RRESP);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)               w_next = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if (w_aw_ok && w_w_ok)      w_next = ST_WR_RESP;
            ST_WR_RESP: if (M_AXI_BVALID)           w_next = ST_RSP;
            ST_RD_REQ:  if (M_AXI_ARREADY)          w_next = ST_RD_RESP;
            ST_RD_RESP: if (M_AXI_RVALID)           w_next = ST_RSP;
            ST_RSP:     if (rsp_ready)              w_next = ST_IDLE;
            default:                                w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_cmd_ready = 1'b1;
            ST_RSP:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_err_count <= 8'd0;
        end else begin
            r_awvalid <= (w_accept && cmd_write)  || (r_awvalid && !M_AXI_AWREADY);
            r_wvalid  <= (w_accept && cmd_write)  || (r_wvalid  && !M_AXI_WREADY);
            r_arvalid <= (w_accept && !cmd_write) || (r_arvalid && !M_AXI_ARREADY);
            // READY flops mirror the upcoming wait state so they rise with it.
            r_bready  <= (w_next == ST_WR_RESP);
            r_rready  <= (w_next == ST_RD_RESP);

            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_wstrb <= cmd_wstrb;
            end

            if (w_b_cap) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= M_AXI_BRESP;
            end else if (w_r_cap) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= M_AXI_RDATA;
                r_rsp_resp  <= M_AXI_RRESP;
            end

            if ((w_b_cap || w_r_cap) && w_cap_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign rsp_valid     = w_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign err_count     = r_err_count;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = C_M_AXI_PROT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = C_M_AXI_PROT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb/tb_axil_master_bridge.sv - randomized self-checking bench for axil_master_bridge
module tb_axil_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [6:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          ref_errs = 0;
    logic [31:0] ref_mem   [32];
    logic [31:0] slave_mem [32];

    always #5 clk = ~clk;

    axil_master_bridge dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic junk_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 7'($urandom);
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_awvalid"}, M_AXI_AWVALID, 0);
        chk({tag, "_wvalid"},  M_AXI_WVALID,  0);
        chk({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        chk({tag, "_bready"},  M_AXI_BREADY,  0);
        chk({tag, "_rready"},  M_AXI_RREADY,  0);
    endtask

    // Accept at cycle 0; each dly counts cycles of READY/VALID withheld by the slave.
    task automatic run_txn(input bit wr, input logic [6:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int d_a, input int d_w, input int d_r,
                           input logic [1:0] resp, input int hold);
        bit          a_done, w_done, r_done;
        int          n, rcnt, lat_exp;
        logic [31:0] exp_rdata;
        logic [4:0]  wi;
        wi = addr[6:2];
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        exp_rdata = 32'd0;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (wstrb[b]) ref_mem[wi][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            exp_rdata = ref_mem[wi];
        end
        if (resp[1] && ref_errs < 255) ref_errs++;
        lat_exp = wr ? 3 + (d_a > d_w ? d_a : d_w) + d_r : 3 + d_a + d_r;
        a_done = 0; w_done = !wr; r_done = 0; n = 0; rcnt = 0;
        while (!r_done && n < 200) begin
            @(posedge clk); #1; n++;
            junk_cmd();
            chk("busy_cmd_ready", cmd_ready, 0);
            chk("busy_rsp_valid", rsp_valid, 0);
            if (wr) begin
                chk("awvalid", M_AXI_AWVALID, !a_done);
                if (!a_done) begin
                    chk("awaddr", M_AXI_AWADDR, addr);
                    chk("awprot", M_AXI_AWPROT, 0);
                end
                chk("wvalid", M_AXI_WVALID, !w_done);
                if (!w_done) begin
                    chk("wdata", M_AXI_WDATA, wdata);
                    chk("wstrb", M_AXI_WSTRB, wstrb);
                end
                chk("bready", M_AXI_BREADY, a_done && w_done);
                chk("wr_arvalid", M_AXI_ARVALID, 0);
                chk("wr_rready", M_AXI_RREADY, 0);
                M_AXI_AWREADY = (n >= 1 + d_a) && !a_done;
                M_AXI_WREADY  = (n >= 1 + d_w) && !w_done;
                M_AXI_BVALID  = a_done && w_done && (rcnt >= d_r);
                M_AXI_BRESP   = M_AXI_BVALID ? resp : 2'($urandom);
                if (a_done && w_done) rcnt++;
                if (M_AXI_BVALID && M_AXI_BREADY) r_done = 1;
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    for (int b = 0; b < 4; b++)
                        if (M_AXI_WSTRB[b]) slave_mem[M_AXI_AWADDR[6:2]][8*b +: 8] = M_AXI_WDATA[8*b +: 8];
                    w_done = 1;
                end
                if (M_AXI_AWVALID && M_AXI_AWREADY) a_done = 1;
            end else begin
                chk("arvalid", M_AXI_ARVALID, !a_done);
                if (!a_done) begin
                    chk("araddr", M_AXI_ARADDR, addr);
                    chk("arprot", M_AXI_ARPROT, 0);
                end
                chk("rready", M_AXI_RREADY, a_done);
                chk("rd_awvalid", M_AXI_AWVALID, 0);
                chk("rd_wvalid", M_AXI_WVALID, 0);
                chk("rd_bready", M_AXI_BREADY, 0);
                M_AXI_ARREADY = (n >= 1 + d_a) && !a_done;
                M_AXI_RVALID  = a_done && (rcnt >= d_r);
                M_AXI_RRESP   = M_AXI_RVALID ? resp : 2'($urandom);
                M_AXI_RDATA   = M_AXI_RVALID ? slave_mem[wi] : $urandom;
                if (a_done) rcnt++;
                if (M_AXI_RVALID && M_AXI_RREADY) r_done = 1;
                if (M_AXI_ARVALID && M_AXI_ARREADY) a_done = 1;
            end
        end
        if (!r_done) begin
            chk("txn_timeout", 0, 1);
            return;
        end
        @(posedge clk); #1;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        chk("latency", n + 1, lat_exp);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin @(posedge clk); #1; end
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_write", rsp_write, wr);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_resp", rsp_resp, resp);
            chk("err_count", err_count, ref_errs);
            chk("rsp_cmd_ready", cmd_ready, 0);
            chk_bus_idle("rsp");
            junk_cmd();
            rsp_ready = (h == hold);
        end
        @(posedge clk); #1;
        rsp_ready = 0; cmd_valid = 0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]   = 32'd0;
            slave_mem[i] = 32'd0;
        end
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_bus_idle("reset");
        chk("reset_awaddr", M_AXI_AWADDR, 0);
        chk("reset_wdata", M_AXI_WDATA, 0);
        chk("reset_wstrb", M_AXI_WSTRB, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_write", rsp_write, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_resp", rsp_resp, 0);
        chk("reset_err_count", err_count, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_reset_cmd_ready", cmd_ready, 1);

        run_txn(1, 7'h40, 32'h8000_0000, 4'b1000, 0, 0, 2, 2'b00, 0);
        run_txn(1, 7'h40, 32'h8000_0000, 4'b1000, 0, 3, 0, 2'b00, 0);
        run_txn(1, 7'h40, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 2'b00, 0);
        run_txn(0, 7'h40, 32'h0,         4'b0000, 2, 0, 3, 2'b00, 0);
        run_txn(0, 7'h40, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 5);

        for (int i = 0; i < 256; i++)
            run_txn(0, 7'($urandom), 32'h0, 4'h0, 0, 0, 0, 2'b10, 0);

        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom), 7'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    2'($urandom), $urandom_range(0, 3));

        cmd_valid = 1; cmd_write = 1; cmd_addr = 7'h10; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 0;
        chk("mid_awvalid", M_AXI_AWVALID, 1);
        @(posedge clk); #1;
        chk("mid_awvalid_held", M_AXI_AWVALID, 1);
        rst = 1;
        @(posedge clk); #1;
        chk_bus_idle("mid_reset");
        chk("mid_reset_rsp_valid", rsp_valid, 0);
        chk("mid_reset_err_count", err_count, 0);
        ref_errs = 0;
        rst = 0;
        @(posedge clk); #1;
        chk("mid_release_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 20; i++)
            run_txn(1'($urandom), 7'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom), $urandom_range(0, 2));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
AXI4-Lite master that converts a simple single-beat command/response interface into compliant AXI4-Lite read and write transactions. It is the initiator counterpart to the team's AXI4-Lite slave register blocks, and serves as the bus driver for firmware-style register access and as a protocol-clean stimulus source. At most one transaction is outstanding at any time. All AXI outputs are registered and held stable while VALID is high, per the AXI handshake rules.

Parameters:
C_M_AXI_ADDR_WIDTH, 7, address width on cmd and AXI address channels
C_M_AXI_DATA_WIDTH, 32, data width (strobe width = C_M_AXI_DATA_WIDTH/8)
C_M_AXI_PROT, 3'b000, constant value driven on AWPROT/ARPROT

Ports:
M_AXI_ACLK  in  1  clock, rising edge
M_AXI_ARESET  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP captured
err_count  out  8  saturating count of SLVERR/DECERR responses
M_AXI_AWADDR/AWPROT/AWVALID out, M_AXI_AWREADY in  write address channel
M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in  write data channel
M_AXI_BRESP in 2, M_AXI_BVALID in, M_AXI_BREADY out  write response channel
M_AXI_ARADDR/ARPROT/ARVALID out, M_AXI_ARREADY in  read address channel
M_AXI_RDATA in, M_AXI_RRESP in 2, M_AXI_RVALID in, M_AXI_RREADY out  read data channel

Behaviour:
- Reset: FSM=IDLE; all AXI VALID/READY outputs 0; address/data/strobe outputs 0; rsp_valid 0, rsp_write 0, rsp_rdata 0, rsp_resp 0; err_count 0. A reset mid-transaction drops every VALID/READY on the next edge and discards the pending response. The module makes no attempt to complete the transaction.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1 (combinational from state only). On cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write and go to WR_REQ or RD_REQ. AWVALID+WVALID (or ARVALID) rise on that same edge, so latency from acceptance to VALID is 1 cycle.
- WR_REQ: AWVALID and WVALID are tracked independently. Each clears on the edge after its own VALID&&READY. Once both handshakes are complete (same cycle or different cycles), go to WR_RESP with BREADY=1. AWADDR/WDATA/WSTRB are never changed while their VALID is high.
- WR_RESP: BREADY=1. On BVALID capture BRESP, set BREADY=0, rsp_write=1, rsp_rdata=0, and go to RSP. BVALID seen before WR_RESP is not accepted because BREADY=0.
- RD_REQ: ARVALID held until ARREADY, then ARVALID=0, RREADY=1, go to RD_RESP.
- RD_RESP: on RVALID capture RDATA/RRESP, set RREADY=0, rsp_write=0, go to RSP.
- RSP: rsp_valid=1 with all rsp_* stable until rsp_ready. Then rsp_valid=0 and return to IDLE. cmd_ready does not rise in the same cycle as the rsp handshake.
- err_count increments by 1 on each captured resp[1]==1 and saturates at 255.
- No timeout: the block waits indefinitely for READY/VALID from the slave.
- Best case write: accept at cycle 0, AW/W handshake at 1, B handshake at 2, rsp_valid at 3. Best case read is the same.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package axil_pkg: AXI response codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), FSM state encoding, default width constants.
- No sub-module: a single FSM plus a saturating counter.

Test Plan:
- Write of 0x80000000 to 0x40, wstrb 4'b1000, AWREADY/WREADY high immediately, BVALID 2 cycles later with OKAY -> one AW and one W handshake; BREADY high only in WR_RESP; rsp_valid with rsp_write=1, rsp_resp=00.
- Same write with AWREADY at cycle 1 and WREADY at cycle 4 -> AWVALID drops after cycle 1; WVALID, WDATA and WSTRB stay stable through cycle 4; BREADY is not asserted before cycle 5.
- Read of 0x40, ARREADY after 2 cycles, RVALID 3 cycles later with data 0xDEADBEEF and OKAY -> ARADDR stable while ARVALID high; rsp_rdata=0xDEADBEEF, rsp_write=0.
- Read returns RRESP=SLVERR, repeated 256 times -> err_count steps 1..255 and stays at 255.
- rsp_ready held low for 5 cycles -> rsp_* stable, cmd_ready=0, no AXI VALID asserted; IDLE and cmd_ready=1 on the cycle after rsp_ready.
- Reset asserted while AWVALID=1 awaiting AWREADY -> all VALID/READY outputs 0 and rsp_valid=0 on the next edge; cmd_ready=1 on the first cycle after reset is released.
